// File: rtl/prt_dptx_trn_ctl_if.sv
// -----------------------------------------------------------------------------
// prt_dptx_trn_ctl_if
// Message-burst bus from the DP TX training sequencer into the training-pattern
// RAM. One beat transfers on every cycle where vld and rdy are both high.
//
// Signals
//   idx    beat index 0..20 (0 = header beat)
//   first  header beat marker (idx 0)
//   last   final beat marker (idx 20)
//   dat    beat data; symbol word in [10:0], upper bits zero
//   vld    beat valid, driven by the sequencer
//   rdy    sink ready, driven by the pattern RAM
//
// Modports
//   master  sequencer side (drives idx/first/last/dat/vld, samples rdy)
//   slave   pattern RAM side
// -----------------------------------------------------------------------------
interface prt_dptx_trn_ctl_if #(
    parameter int unsigned P_MSG_IDX = 5,
    parameter int unsigned P_MSG_DAT = 16
);

    logic [P_MSG_IDX-1:0] idx;
    logic                 first;
    logic                 last;
    logic [P_MSG_DAT-1:0] dat;
    logic                 vld;
    logic                 rdy;

    modport master (
        output idx,
        output first,
        output last,
        output dat,
        output vld,
        input  rdy
    );

    modport slave (
        input  idx,
        input  first,
        input  last,
        input  dat,
        input  vld,
        output rdy
    );

endinterface

// File: rtl/prt_dptx_trn_ctl.sv
// -----------------------------------------------------------------------------
// prt_dptx_trn_ctl
// Sequencer for the DP TX training block. On a host request it streams the
// selected link training pattern (TPS1/TPS2) as a 21-beat message burst into
// the training-pattern RAM, waits a settle time, then switches the lane mux to
// training. A TPS0 request returns the lanes to the main link.
//
// Ports
//   clk       clock
//   rst       synchronous reset, active-high
//   ctl_req   request pulse, sampled together with ctl_tps
//   ctl_tps   0 main link, 1 TPS1, 2 TPS2, 3 illegal
//   trn_sel   lane mux select: 0 main link, 1 training
//   msg       message-burst bus (master side)
//   sta_busy  high while loading or settling
//   sta_done  1-cycle pulse: requested state reached
//   sta_rej   1-cycle pulse: request rejected
//   sta_tps   pattern currently driven on the lanes (0 when main link)
// -----------------------------------------------------------------------------
module prt_dptx_trn_ctl #(
    parameter int unsigned P_SPL     = 2,
    parameter int unsigned P_MSG_IDX = 5,
    parameter int unsigned P_MSG_DAT = 16,
    parameter int unsigned P_SETTLE  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ctl_req,
    input  logic [1:0]                ctl_tps,
    output logic                      trn_sel,
    prt_dptx_trn_ctl_if.master        msg,
    output logic                      sta_busy,
    output logic                      sta_done,
    output logic                      sta_rej,
    output logic [1:0]                sta_tps
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    // The 20-symbol pattern must split evenly across lanes at P_SPL symbols/clk.
    if (!(P_SPL == 1 || P_SPL == 2 || P_SPL == 4)) begin : g_bad_spl
        $error("prt_dptx_trn_ctl: P_SPL must be 1, 2 or 4");
    end
    if (P_MSG_IDX < 5) begin : g_bad_idx
        $error("prt_dptx_trn_ctl: P_MSG_IDX must hold 0..20");
    end
    if (P_MSG_DAT < 11) begin : g_bad_dat
        $error("prt_dptx_trn_ctl: P_MSG_DAT must be at least 11");
    end
    if (P_SETTLE < 1 || P_SETTLE > 255) begin : g_bad_settle
        $error("prt_dptx_trn_ctl: P_SETTLE must be 1..255");
    end

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [P_MSG_IDX-1:0] IdxLast   = P_MSG_IDX'(20);
    localparam logic [P_MSG_IDX-1:0] IdxHalf   = P_MSG_IDX'(10);
    localparam logic [7:0]           SettleTop = 8'(P_SETTLE - 1);

    // Symbol words {disp_ctl, disp_val, k, dat[7:0]}
    localparam logic [10:0] SymD10p2   = 11'h04A;  // D10.2
    localparam logic [10:0] SymD11p6   = 11'h0CB;  // D11.6
    localparam logic [10:0] SymK28p5Np = 11'h5BC;  // K28.5, forced negative disparity
    localparam logic [10:0] SymK28p5Pp = 11'h7BC;  // K28.5, forced positive disparity

    localparam logic [1:0] TpsMain = 2'd0;
    localparam logic [1:0] Tps1    = 2'd1;
    localparam logic [1:0] Tps2    = 2'd2;
    localparam logic [1:0] TpsBad  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSettle,
        StActive
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [P_MSG_IDX-1:0] idx_q, idx_d;
    logic [7:0]           settle_q, settle_d;
    logic [1:0]           tps_q, tps_d;        // pattern being loaded / last loaded
    logic                 sel_q, sel_d;
    logic [1:0]           sta_tps_q, sta_tps_d;
    logic                 done_q, done_d;
    logic                 rej_q, rej_d;

    logic                 in_load;
    logic                 beat_xfer;
    logic [3:0]           tps2_pos;
    logic [10:0]          sym_word;

    assign in_load   = (state_q == StLoad);
    assign beat_xfer = in_load & msg.rdy;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            settle_q  <= '0;
            tps_q     <= TpsMain;
            sel_q     <= 1'b0;
            sta_tps_q <= TpsMain;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            tps_q     <= tps_d;
            sel_q     <= sel_d;
            sta_tps_q <= sta_tps_d;
            done_q    <= done_d;
            rej_q     <= rej_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        tps_d     = tps_q;
        sel_d     = sel_q;
        sta_tps_d = sta_tps_q;
        done_d    = 1'b0;
        rej_d     = 1'b0;

        unique case (state_q)
            StIdle, StActive: begin
                if (ctl_req) begin
                    unique case (ctl_tps)
                        TpsMain: begin
                            sel_d     = 1'b0;
                            sta_tps_d = TpsMain;
                            done_d    = 1'b1;
                            state_d   = StIdle;
                        end
                        Tps1, Tps2: begin
                            // Lanes leave training while the RAM is rewritten.
                            sel_d     = 1'b0;
                            sta_tps_d = TpsMain;
                            tps_d     = ctl_tps;
                            idx_d     = '0;
                            state_d   = StLoad;
                        end
                        TpsBad: begin
                            rej_d = 1'b1;
                        end
                        default: begin
                            rej_d = 1'b1;
                        end
                    endcase
                end
            end

            StLoad: begin
                if (ctl_req) begin
                    rej_d = 1'b1;
                end
                if (beat_xfer) begin
                    if (idx_q == IdxLast) begin
                        idx_d    = '0;
                        settle_d = SettleTop;
                        state_d  = StSettle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            StSettle: begin
                if (settle_q == 8'd0) begin
                    state_d   = StActive;
                    sel_d     = 1'b1;
                    sta_tps_d = tps_q;
                    done_d    = 1'b1;
                    // A request landing on this final cycle is still ignored, but
                    // its REJ is dropped so DONE and REJ never coincide.
                end else begin
                    settle_d = settle_q - 1'b1;
                    if (ctl_req) begin
                        rej_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pattern symbol lookup
    // -------------------------------------------------------------------------
    // TPS2 repeats a 10-symbol period over beats 1..20; fold to position 0..9.
    always_comb begin
        tps2_pos = 4'd0;
        if (idx_q != '0) begin
            if (idx_q <= IdxHalf) begin
                tps2_pos = 4'(idx_q - 1'b1);
            end else begin
                tps2_pos = 4'(idx_q - IdxHalf - 1'b1);
            end
        end
    end

    always_comb begin
        sym_word = SymD10p2;
        if (idx_q == '0) begin
            // Header beat carries the pattern code.
            sym_word = {9'd0, tps_q};
        end else if (tps_q == Tps2) begin
            unique case (tps2_pos)
                4'd0:    sym_word = SymK28p5Np;
                4'd1:    sym_word = SymD11p6;
                4'd2:    sym_word = SymK28p5Pp;
                4'd3:    sym_word = SymD11p6;
                default: sym_word = SymD10p2;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Message fields are qualified by LOAD so the bus reads all-zero when idle;
    // while stalled they hold because idx_q and tps_q only move on a transfer.
    always_comb begin
        msg.vld   = in_load;
        msg.idx   = in_load ? idx_q : '0;
        msg.first = in_load && (idx_q == '0);
        msg.last  = in_load && (idx_q == IdxLast);
        msg.dat   = '0;
        if (in_load) begin
            msg.dat[10:0] = sym_word;
        end
    end

    assign trn_sel  = sel_q;
    assign sta_busy = (state_q == StLoad) || (state_q == StSettle);
    assign sta_done = done_q;
    assign sta_rej  = rej_q;
    assign sta_tps  = sta_tps_q;

endmodule
